// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit holding the architectural HI/LO
// registers. MULT/MULTU/DIV/DIVU run for 32 cycles with busy asserted; the
// result lands on hi/lo at the edge where busy falls. MTHI/MTLO writes are
// accepted only while idle.
//
// Optional build macro: MULDIV_FAST_MULT_EN
//   defined   -> MULT/MULTU use a single-cycle 64-bit multiplier (latency 1)
//   undefined -> MULT/MULTU use shift-add, one multiplier bit per cycle
// Divides always use restoring division, one quotient bit per cycle.
`timescale 1ns/1ps

module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand1,
    input  logic [WIDTH-1:0] operand2,
    input  logic             hi_write,
    input  logic             lo_write,
    input  logic [WIDTH-1:0] write_data,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;

    // Operation context captured at the accepting edge
    logic               is_div_q;
    logic               neg_lo_q;      // negate product / quotient at writeback
    logic               neg_hi_q;      // negate remainder at writeback
    logic               div0_q;
    logic [WIDTH-1:0]   dividend_q;    // raw rs, returned in hi on divide by zero
    logic [WIDTH-1:0]   mcand_q;       // |multiplicand| or |divisor|
    // Multiply: {partial product high half, remaining multiplier bits}
    // Divide:   {partial remainder, dividend bits shifting into quotient}
    logic [2*WIDTH-1:0] work_q;

    logic               accept;
    logic               last_iter;
    logic               is_signed;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH-1:0]   div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] work_next;
    logic [2*WIDTH-1:0] mul_result;
    logic [2*WIDTH-1:0] prod_signed;
    logic [WIDTH-1:0]   hi_res;
    logic [WIDTH-1:0]   lo_res;

    // Absolute value of a two's-complement operand when the op is signed
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic is_sgn);
        logic signed [WIDTH-1:0] s;
        s = v;
        return (is_sgn && (s < 0)) ? (~v + 1'b1) : v;
    endfunction

    // Conditional two's-complement negation of a single-width result
    function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v,
                                                    input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    // Conditional two's-complement negation of a double-width product
    function automatic logic [2*WIDTH-1:0] apply_sign_wide(input logic [2*WIDTH-1:0] v,
                                                           input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    assign accept    = (state_q == IDLE) && start;
    assign is_signed = ~op[0];

`ifdef MULDIV_FAST_MULT_EN
    logic [2*WIDTH-1:0] fast_prod;
    assign fast_prod  = {{WIDTH{1'b0}}, work_q[WIDTH-1:0]} * {{WIDTH{1'b0}}, mcand_q};
    assign last_iter  = is_div_q ? (cnt_q == CNT_W'(WIDTH-1)) : (cnt_q == '0);
    assign mul_result = fast_prod;
`else
    assign last_iter  = (cnt_q == CNT_W'(WIDTH-1));
    assign mul_result = work_next;
`endif

    // One iteration of shift-add multiply and restoring divide, plus writeback values
    always_comb begin
        mul_sum     = {1'b0, work_q[2*WIDTH-1:WIDTH]}
                    + (work_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
        mul_next    = {mul_sum, work_q[WIDTH-1:1]};

        div_shift   = {work_q[2*WIDTH-1:WIDTH], work_q[WIDTH-1]};
        div_ge      = (div_shift >= {1'b0, mcand_q});
        div_diff    = div_shift[WIDTH-1:0] - mcand_q;
        div_next    = div_ge ? {div_diff, work_q[WIDTH-2:0], 1'b1}
                             : {div_shift[WIDTH-1:0], work_q[WIDTH-2:0], 1'b0};

        work_next   = is_div_q ? div_next : mul_next;

        prod_signed = apply_sign_wide(mul_result, neg_lo_q);
        hi_res      = prod_signed[2*WIDTH-1:WIDTH];
        lo_res      = prod_signed[WIDTH-1:0];
        if (is_div_q) begin
            if (div0_q) begin
                lo_res = {WIDTH{1'b1}};
                hi_res = dividend_q;
            end else begin
                lo_res = apply_sign(work_next[WIDTH-1:0], neg_lo_q);
                hi_res = apply_sign(work_next[2*WIDTH-1:WIDTH], neg_hi_q);
            end
        end
    end

    // Control FSM and architectural HI/LO registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= RUN;
                        cnt_q   <= '0;
                        busy    <= 1'b1;
                    end else begin
                        if (hi_write) hi <= write_data;
                        if (lo_write) lo <= write_data;
                    end
                end
                RUN: begin
                    if (last_iter) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        busy    <= 1'b0;
                        hi      <= hi_res;
                        lo      <= lo_res;
                    end else begin
                        cnt_q   <= cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Operand capture at issue, then one datapath iteration per RUN cycle
    always_ff @(posedge clk) begin
        if (accept) begin
            is_div_q   <= op[1];
            neg_lo_q   <= is_signed & (operand1[WIDTH-1] ^ operand2[WIDTH-1]);
            neg_hi_q   <= is_signed & operand1[WIDTH-1];
            div0_q     <= (operand2 == '0);
            dividend_q <= operand1;
            mcand_q    <= magnitude(operand2, is_signed);
            work_q     <= {{WIDTH{1'b0}}, magnitude(operand1, is_signed)};
        end else if (state_q == RUN) begin
            work_q     <= work_next;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases plus randomized
// operations compared against a plain-arithmetic reference model.
`timescale 1ns/1ps

module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] operand1;
    logic [31:0] operand2;
    logic        hi_write;
    logic        lo_write;
    logic [31:0] write_data;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks = 0;
    int n_fail   = 0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .op         (op),
        .operand1   (operand1),
        .operand2   (operand2),
        .hi_write   (hi_write),
        .lo_write   (lo_write),
        .write_data (write_data),
        .busy       (busy),
        .hi         (hi),
        .lo         (lo)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Architectural result of an operation, from plain integer arithmetic
    function automatic void model(input logic [1:0] o, input logic [31:0] a,
                                  input logic [31:0] b,
                                  output logic [31:0] eh, output logic [31:0] el);
        longint      sp;
        logic [63:0] up;
        int          sa;
        int          sb;
        case (o)
            2'b00: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                up = sp;
                eh = up[63:32];
                el = up[31:0];
            end
            2'b01: begin
                up = {32'b0, a} * {32'b0, b};
                eh = up[63:32];
                el = up[31:0];
            end
            default: begin
                if (b == 32'd0) begin
                    el = 32'hFFFF_FFFF;
                    eh = a;
                end else if (o == 2'b11) begin
                    el = a / b;
                    eh = a % b;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    el = 32'h8000_0000;
                    eh = 32'd0;
                end else begin
                    sa = $signed(a);
                    sb = $signed(b);
                    el = sa / sb;
                    eh = sa % sb;
                end
            end
        endcase
    endfunction

    function automatic int latency(input logic [1:0] o);
`ifdef MULDIV_FAST_MULT_EN
        return o[1] ? 32 : 1;
`else
        return (o == 2'b00) ? 32 : 32;
`endif
    endfunction

    // Issue one operation from a negedge with busy low; returns at the negedge
    // after busy falls. disturb >= 0 pulses start+hi_write on that busy cycle.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input string tag, input int disturb, input bit with_hw);
        logic [31:0] eh;
        logic [31:0] el;
        logic [63:0] prev;
        int          cyc;
        bit          held;
        model(o, a, b, eh, el);
        prev     = {hi, lo};
        start    = 1'b1;
        op       = o;
        operand1 = a;
        operand2 = b;
        if (with_hw) begin
            hi_write   = 1'b1;
            write_data = 32'hA5A5_5A5A;
        end
        @(negedge clk);
        start    = 1'b0;
        hi_write = 1'b0;
        op       = 2'($urandom);
        operand1 = $urandom;
        operand2 = $urandom;
        cyc  = 0;
        held = 1'b1;
        while (busy === 1'b1 && cyc < 100) begin
            if ({hi, lo} !== prev) held = 1'b0;
            if (cyc == disturb) begin
                start      = 1'b1;
                hi_write   = 1'b1;
                write_data = 32'h4242_4242;
                operand1   = $urandom;
                operand2   = $urandom;
            end else begin
                start    = 1'b0;
                hi_write = 1'b0;
            end
            cyc++;
            @(negedge clk);
        end
        start    = 1'b0;
        hi_write = 1'b0;
        check_val($sformatf("%s.busy_cycles", tag), 64'(cyc), 64'(latency(o)));
        check_val($sformatf("%s.held_during_run", tag), 64'(held), 64'd1);
        check_val($sformatf("%s.hi", tag), {32'b0, hi}, {32'b0, eh});
        check_val($sformatf("%s.lo", tag), {32'b0, lo}, {32'b0, el});
        if (disturb >= 0)
            check_val($sformatf("%s.hi_not_mthi", tag), 64'(hi == 32'h4242_4242), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [1:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;
        reset_n    = 1'b0;
        start      = 1'b0;
        op         = 2'b00;
        operand1   = '0;
        operand2   = '0;
        hi_write   = 1'b0;
        lo_write   = 1'b0;
        write_data = '0;
        #1;
        check_val("reset.busy", {63'b0, busy}, 64'd0);
        check_val("reset.hi", {32'b0, hi}, 64'd0);
        check_val("reset.lo", {32'b0, lo}, 64'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max", -1, 1'b0);
        check_val("multu_max.hi_const", {32'b0, hi}, 64'hFFFF_FFFE);
        check_val("multu_max.lo_const", {32'b0, lo}, 64'h0000_0001);
        run_op(2'b00, 32'hFFFF_FFFD, 32'd7, "mult_neg3x7", -1, 1'b0);
        check_val("mult_neg3x7.hi_const", {32'b0, hi}, 64'hFFFF_FFFF);
        check_val("mult_neg3x7.lo_const", {32'b0, lo}, 64'hFFFF_FFEB);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, "div_neg7by2", -1, 1'b0);
        check_val("div_neg7by2.lo_const", {32'b0, lo}, 64'hFFFF_FFFD);
        check_val("div_neg7by2.hi_const", {32'b0, hi}, 64'hFFFF_FFFF);
        run_op(2'b11, 32'd100, 32'd0, "divu_by0", -1, 1'b0);
        check_val("divu_by0.lo_const", {32'b0, lo}, 64'hFFFF_FFFF);
        check_val("divu_by0.hi_const", {32'b0, hi}, 64'd100);
        run_op(2'b10, 32'hFFFF_FF85, 32'd0, "div_neg_by0", -1, 1'b0);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf", -1, 1'b0);
        check_val("div_ovf.lo_const", {32'b0, lo}, 64'h8000_0000);
        check_val("div_ovf.hi_const", {32'b0, hi}, 64'd0);

        // Start and MTHI pulsed while busy must be ignored
        run_op(2'b10, 32'd1000, 32'hFFFF_FFF9, "div_disturb", 5, 1'b0);
        run_op(2'b01, 32'h1234_5678, 32'h9ABC_DEF0, "multu_disturb", 0, 1'b0);

        // MTHI and MTLO together, then separately
        hi_write   = 1'b1;
        lo_write   = 1'b1;
        write_data = 32'hDEED_BEEF;
        @(negedge clk);
        hi_write = 1'b0;
        lo_write = 1'b0;
        check_val("mthi_mtlo.hi", {32'b0, hi}, 64'hDEED_BEEF);
        check_val("mthi_mtlo.lo", {32'b0, lo}, 64'hDEED_BEEF);
        hi_write   = 1'b1;
        write_data = 32'h1111_2222;
        @(negedge clk);
        hi_write = 1'b0;
        check_val("mthi_only.hi", {32'b0, hi}, 64'h1111_2222);
        check_val("mthi_only.lo", {32'b0, lo}, 64'hDEED_BEEF);
        lo_write   = 1'b1;
        write_data = 32'h3333_4444;
        @(negedge clk);
        lo_write = 1'b0;
        check_val("mtlo_only.hi", {32'b0, hi}, 64'h1111_2222);
        check_val("mtlo_only.lo", {32'b0, lo}, 64'h3333_4444);

        // hi_write in the same cycle as an accepted start loses to the start
        run_op(2'b11, 32'd50, 32'd6, "divu_start_hw", -1, 1'b1);
        run_op(2'b00, 32'h0000_0009, 32'hFFFF_FFFF, "mult_start_hw", -1, 1'b1);

        // Randomized operations
        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom);
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: begin ra = $urandom_range(0, 300); rb = $urandom_range(1, 20); end
                3: begin ra = -$urandom_range(0, 300); rb = $urandom_range(1, 20); end
                4: rb = rb >> $urandom_range(0, 31);
                default: ;
            endcase
            run_op(ro, ra, rb, $sformatf("rand%0d_op%0d", i, ro), -1, 1'b0);
        end

        // Asynchronous reset in the middle of a divide
        hi_write   = 1'b1;
        lo_write   = 1'b1;
        write_data = 32'h1234_5678;
        @(negedge clk);
        hi_write = 1'b0;
        lo_write = 1'b0;
        start    = 1'b1;
        op       = 2'b11;
        operand1 = 32'hFFFF_0000;
        operand2 = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check_val("midrst.busy_before", {63'b0, busy}, 64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check_val("midrst.busy", {63'b0, busy}, 64'd0);
        check_val("midrst.hi", {32'b0, hi}, 64'd0);
        check_val("midrst.lo", {32'b0, lo}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check_val("after_rst.busy", {63'b0, busy}, 64'd0);
        run_op(2'b11, 32'd9, 32'd2, "divu_after_rst", -1, 1'b0);
        check_val("divu_after_rst.lo_const", {32'b0, lo}, 64'd4);
        check_val("divu_after_rst.hi_const", {32'b0, hi}, 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
